// File: rtl/ctx_regfile.sv
// Register file with NCTX context banks; save/load/swap between the active file and a
// bank run one register per cycle so the banks can later move into block RAM.

// Zero-latency read port; register 0 is hard-wired to zero.
module ctx_regfile_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                  addr,
  output logic [DATA_W-1:0]                  data
);
  assign data = (addr == '0) ? '0 : regs[addr];
endmodule

module ctx_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTX_W  = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic [CTX_W-1:0]  ctx_sel,
  input  logic              save_req,
  input  logic              load_req,
  output logic              busy,
  output logic              done
);
  localparam int NREG = 2**ADDR_W;
  localparam int NCTX = 2**CTX_W;
  localparam int NRD  = 2;

  typedef enum logic [1:0] {IDLE, SAVE, LOAD, SWAP} state_t;

  state_t                                   state, state_nxt;
  logic [ADDR_W-1:0]                        idx;
  logic [CTX_W-1:0]                         ctx_q;
  logic                                     last;
  logic [NREG-1:0][DATA_W-1:0]              act;
  logic [NCTX-1:0][NREG-1:0][DATA_W-1:0]    bank;
  logic [NRD-1:0][ADDR_W-1:0]               rd_addr;
  logic [NRD-1:0][DATA_W-1:0]               rd_data;

  // Terminal index is compared explicitly; idx wraps afterwards but is never used.
  assign last = (idx == ADDR_W'(NREG-1));

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (save_req && load_req) state_nxt = SWAP;
        else if (save_req)        state_nxt = SAVE;
        else if (load_req)        state_nxt = LOAD;
      end
      default: if (last) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // SWAP relies on non-blocking semantics: both directions read pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) begin
      act   <= '0;
      bank  <= '0;
      idx   <= '0;
      ctx_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (wr_en && wr_addr != '0) act[wr_addr] <= wr_data;
        if (save_req || load_req) begin
          ctx_q <= ctx_sel;
          idx   <= ADDR_W'(1);
        end
      end else begin
        if (state != LOAD) bank[ctx_q][idx] <= act[idx];
        if (state != SAVE) act[idx] <= bank[ctx_q][idx];
        idx <= idx + 1'b1;
        if (last) done <= 1'b1;
      end
    end
  end

  assign rd_addr = {rt_addr, rs_addr};

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    ctx_regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .regs (act),
      .addr (rd_addr[p]),
      .data (rd_data[p])
    );
  end

  assign rd_data1 = rd_data[0];
  assign rd_data2 = rd_data[1];

endmodule

// File: doc/ctx_regfile.md
# ctx_regfile

Parametrised register file with multiple context banks and sequenced save, load and swap between the active file and a selected bank. It replaces the single-bank register file that dumps every register in one cycle. Context transfers run one register per cycle, so banks can later be remapped to block RAM. It sits between instruction decode and the ALU in the processor datapath; `busy` stalls the PC while a context transfer runs.

## Interface
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: register address width; NREG = 2**ADDR_W.
- `CTX_W`, default 2: context select width; NCTX = 2**CTX_W banks.
- `CLK`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `rs_addr`, input, ADDR_W: read port 1 address.
- `rt_addr`, input, ADDR_W: read port 2 address.
- `wr_addr`, input, ADDR_W: write address.
- `wr_data`, input, DATA_W: write data.
- `wr_en`, input, 1: write enable.
- `rd_data1`, output, DATA_W: combinational read of the active register at `rs_addr`.
- `rd_data2`, output, DATA_W: combinational read of the active register at `rt_addr`.
- `ctx_sel`, input, CTX_W: bank targeted by a request.
- `save_req`, input, 1: copy the active file into bank `ctx_sel`.
- `load_req`, input, 1: copy bank `ctx_sel` into the active file.
- `busy`, output, 1: a transfer is in progress.
- `done`, output, 1: one-cycle pulse when a transfer completes.

## Operation
- Storage:
  - Active file is act[0..NREG-1].
  - Banks are bank[c][0..NREG-1].
  - Register 0 reads as 0 everywhere and is never written or transferred.
- States: IDLE, SAVE, LOAD, SWAP. Index counter `idx` has width ADDR_W.
- In IDLE, sampled at a rising edge, priority order:
  - `save_req` and `load_req` both high → SWAP.
  - `save_req` only → SAVE.
  - `load_req` only → LOAD.
  - On entry: `ctx_sel` is latched into `ctx_q` and `idx` is set to 1.
- Each transfer-state edge acts on index `idx`:
  - SAVE: bank[ctx_q][idx] ← act[idx].
  - LOAD: act[idx] ← bank[ctx_q][idx].
  - SWAP: both moves happen on the same edge, using pre-edge values.
- Counter and exit:
  - `idx` increments after each copy.
  - The edge that copies `idx` = NREG-1 returns the block to IDLE and sets `done`.
- Normal writes:
  - In IDLE, `wr_en` with `wr_addr` ≠ 0 writes act[wr_addr] ← `wr_data`.
  - Outside IDLE, `wr_en` is ignored.
  - A write in the same IDLE cycle as a request still takes effect. The first transfer edge then uses the written value.
- Requests outside IDLE are ignored; they are not queued.
- Changes to `ctx_sel` during a transfer have no effect.
- Reads during a transfer return the current act contents. During LOAD/SWAP, indices below `idx` already hold the new values.
- Reset: act, every bank, `idx` and `ctx_q` are cleared to 0; state goes to IDLE; `busy` = 0, `done` = 0. This applies mid-transfer too; the transfer is abandoned and not resumed.

## Timing
- Request sampled at edge E0. `busy` is high from E0 through E(NREG-1): NREG-1 cycles, 31 at the defaults.
- `busy` = (state ≠ IDLE).
- `done` is a registered pulse, high exactly one cycle after E(NREG-1), concurrent with the block being back in IDLE.
- A new request can be accepted at the edge that ends the `done` cycle. Back-to-back throughput is one transfer per NREG cycles.
- Read ports have zero latency. A write is visible on the read ports the cycle after its edge; there is no write-to-read bypass.
- Index wrap: `idx` is never used past NREG-1. Terminal detection compares against NREG-1, not overflow.

## Test plan
- Reset, then write the ten words act[1..10] ← 0x11·i; read every address → the expected values, and r0 always 0 even after a write to r0.
- Write act[5]=0xDEAD, request save at ctx 2 → `busy` high exactly 31 cycles, then a single `done` pulse. Overwrite act[5]=0, load ctx 2 → act[5] reads 0xDEAD after `done`.
- Fill act with 0xA000+i and bank 1 with 0xB000+i; assert save and load together at ctx 1 → after `done`, act[i]=0xB000+i and bank 1 holds 0xA000+i (verified via a later load).
- During SAVE: `wr_en` to r7 ignored, `load_req` ignored, `ctx_sel` toggled → the bank contents and the target bank are unchanged from the latched request.
- During LOAD: sample `rd_data1` at r3 and r20 at idx=10 → r3 shows the bank value, r20 shows the old value.
- Assert `reset` at idx=15 of a SAVE → the next cycle shows `busy`=0, `done`=0, every act and bank register reads 0, and no `done` pulse follows.
